// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversampling, bit and mid-bit tick generator with
// glitch-free run-time divisor reload and start-bit phase restart.
module uart_baud_gen #(
    parameter int DIV_W       = 16,
    parameter int OVS         = 8,
    parameter int DEFAULT_DIV = 651
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    input  logic             rx_sync,
    output logic             sample_tick,
    output logic             bit_tick,
    output logic             mid_tick,
    output logic             load_pending,
    output logic [DIV_W-1:0] div_cur
);

    localparam int PH_W = $clog2(OVS);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(OVS - 1);
    localparam logic [PH_W-1:0]  PH_MID  = PH_W'(OVS / 2 - 1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_shadow;
    logic [DIV_W-1:0] div_act;
    logic [PH_W-1:0]  ph;

    logic term;
    logic apply;
    logic tick_ok;

    assign term    = enable && (cnt == div_act);
    assign tick_ok = term && !rx_sync;
    assign div_cur = div_act;

    // Swap divisors only on a period boundary, a phase restart or
    // while stalled, so a running period is never cut or stretched.
    assign apply = load_pending && (term || rx_sync || !enable);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ph  <= '0;
        end else if (rx_sync) begin
            cnt <= '0;
            ph  <= '0;
        end else if (term) begin
            cnt <= '0;
            if (ph == PH_LAST) begin
                ph <= '0;
            end else begin
                ph <= ph + 1'b1;
            end
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_act      <= DIV_RST;
            div_shadow   <= DIV_RST;
            load_pending <= 1'b0;
        end else begin
            if (apply) begin
                div_act <= div_shadow;
            end
            if (div_load) begin
                div_shadow   <= (div_in == '0) ? DIV_ONE : div_in;
                load_pending <= 1'b1;
            end else if (apply) begin
                load_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_tick <= 1'b0;
            bit_tick    <= 1'b0;
            mid_tick    <= 1'b0;
        end else begin
            sample_tick <= tick_ok;
            bit_tick    <= tick_ok && (ph == PH_LAST);
            mid_tick    <= tick_ok && (ph == PH_MID);
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: directed scenarios plus random stimulus
// against a remaining-cycles / tick-count reference model.
module tb_uart_baud_gen;

    localparam int DEF = 651;
    localparam int OVS = 8;
    localparam int PER = DEF + 1;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] div_in;
    logic        div_load;
    logic        rx_sync;
    logic        sample_tick;
    logic        bit_tick;
    logic        mid_tick;
    logic        load_pending;
    logic [15:0] div_cur;

    int checks;
    int errors;
    int edge_no;

    logic [15:0] m_div;
    logic [15:0] m_shadow;
    logic        m_pend;
    logic        m_st;
    logic        m_bt;
    logic        m_mt;
    int          m_rem;
    int          m_nt;

    uart_baud_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .div_in       (div_in),
        .div_load     (div_load),
        .rx_sync      (rx_sync),
        .sample_tick  (sample_tick),
        .bit_tick     (bit_tick),
        .mid_tick     (mid_tick),
        .load_pending (load_pending),
        .div_cur      (div_cur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] obs_vec();
        return {sample_tick, bit_tick, mid_tick, load_pending, div_cur};
    endfunction

    function automatic logic [19:0] exp_vec();
        return {m_st, m_bt, m_mt, m_pend, m_div};
    endfunction

    function automatic void model_reset();
        m_div    = 16'(DEF);
        m_shadow = 16'(DEF);
        m_pend   = 1'b0;
        m_st     = 1'b0;
        m_bt     = 1'b0;
        m_mt     = 1'b0;
        m_rem    = DEF + 1;
        m_nt     = 0;
        edge_no  = 0;
    endfunction

    // Called at a negedge; drives inputs, advances one rising edge,
    // updates the model, returns at the following negedge.
    task automatic step(input logic en_i, input logic sy_i,
                        input logic ld_i, input logic [15:0] din_i);
        logic term_now;
        logic app;
        enable   = en_i;
        rx_sync  = sy_i;
        div_load = ld_i;
        div_in   = din_i;
        @(posedge clk);
        edge_no++;
        term_now = en_i && (m_rem == 1);
        app      = m_pend && (term_now || sy_i || !en_i);
        m_st = 1'b0;
        m_bt = 1'b0;
        m_mt = 1'b0;
        if (app) begin
            if (!sy_i && !term_now) begin
                m_rem = m_rem + int'(m_shadow) - int'(m_div);
            end
            m_div  = m_shadow;
            m_pend = 1'b0;
        end
        if (sy_i) begin
            m_rem = int'(m_div) + 1;
            m_nt  = 0;
        end else if (term_now) begin
            m_nt++;
            m_st  = 1'b1;
            m_bt  = (m_nt % OVS) == 0;
            m_mt  = (m_nt % OVS) == OVS / 2;
            m_rem = int'(m_div) + 1;
        end else if (en_i) begin
            m_rem--;
        end
        if (ld_i) begin
            m_shadow = (din_i == 16'd0) ? 16'd1 : din_i;
            m_pend   = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        enable   = 1'b0;
        rx_sync  = 1'b0;
        div_load = 1'b0;
        div_in   = 16'd0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        enable   = 1'b0;
        rx_sync  = 1'b0;
        div_load = 1'b0;
        div_in   = 16'd0;
        model_reset();
        #12;
        checks++;
        if (obs_vec() !== {4'b0000, 16'(DEF)}) begin
            errors++;
            $display("FAIL reset_vals got %h want %h",
                     obs_vec(), {4'b0000, 16'(DEF)});
        end
        @(negedge clk);
    endtask

    // Edge n closes cycle n, so a tick registered at edge n is seen
    // in cycle n+1: edge 652 here is cycle 653 of the timing rules.
    task automatic run_default_timing(input int ncyc);
        int first_st;
        int last_st;
        int last_bt;
        int n_bt;
        int first_mt;
        first_st = -1;
        last_st  = -1;
        last_bt  = -1;
        n_bt     = 0;
        first_mt = -1;
        for (int i = 0; i < ncyc; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'd0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL dflt_model edge %0d got %h want %h",
                         edge_no, obs_vec(), exp_vec());
            end
            if (sample_tick) begin
                if (first_st < 0) begin
                    first_st = edge_no;
                end else begin
                    checks++;
                    if (edge_no - last_st != PER) begin
                        errors++;
                        $display("FAIL st_period got %0d want %0d",
                                 edge_no - last_st, PER);
                    end
                end
                last_st = edge_no;
            end
            if (mid_tick) begin
                if (first_mt < 0) first_mt = edge_no;
                if (last_bt >= 0) begin
                    checks++;
                    if (edge_no - last_bt != PER * OVS / 2) begin
                        errors++;
                        $display("FAIL mid_after_bit got %0d want %0d",
                                 edge_no - last_bt, PER * OVS / 2);
                    end
                end
            end
            if (bit_tick) begin
                if (last_bt >= 0) begin
                    checks++;
                    if (edge_no - last_bt != PER * OVS) begin
                        errors++;
                        $display("FAIL bt_period got %0d want %0d",
                                 edge_no - last_bt, PER * OVS);
                    end
                end
                last_bt = edge_no;
                n_bt++;
            end
        end
        checks++;
        if (first_st != PER) begin
            errors++;
            $display("FAIL first_st got %0d want %0d", first_st, PER);
        end
        checks++;
        if (first_mt != PER * OVS / 2) begin
            errors++;
            $display("FAIL first_mt got %0d want %0d",
                     first_mt, PER * OVS / 2);
        end
        checks++;
        if (n_bt != ncyc / (PER * OVS)) begin
            errors++;
            $display("FAIL n_bit got %0d want %0d",
                     n_bt, ncyc / (PER * OVS));
        end
    endtask

    task automatic test_defaults();
        apply_reset();
        run_default_timing(11000);
    endtask

    task automatic test_reload();
        int st_edges[$];
        int rise;
        int fall;
        logic ld;
        rise = -1;
        fall = -1;
        apply_reset();
        for (int i = 0; i < 1400; i++) begin
            ld = (edge_no + 1 == 100);
            step(1'b1, 1'b0, ld, ld ? 16'd325 : 16'd0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reload_model edge %0d got %h want %h",
                         edge_no, obs_vec(), exp_vec());
            end
            if (sample_tick) st_edges.push_back(edge_no);
            if (load_pending && rise < 0) rise = edge_no;
            if (!load_pending && rise >= 0 && fall < 0) fall = edge_no;
        end
        checks++;
        if (st_edges.size() < 3 || st_edges[0] != 652 ||
            st_edges[1] != 978 || st_edges[2] != 1304) begin
            errors++;
            $display("FAIL reload_ticks got %p want 652 978 1304",
                     st_edges);
        end
        checks++;
        if (rise != 100 || fall != 652) begin
            errors++;
            $display("FAIL reload_pend got %0d..%0d want 100..652",
                     rise, fall);
        end
    endtask

    task automatic test_phase_sync();
        int s;
        int mt;
        int bt;
        logic sy;
        s  = PER + 300;
        mt = -1;
        bt = -1;
        apply_reset();
        for (int i = 0; i < s + PER * OVS + 20; i++) begin
            sy = (edge_no + 1 == s);
            step(1'b1, sy, 1'b0, 16'd0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL sync_model edge %0d got %h want %h",
                         edge_no, obs_vec(), exp_vec());
            end
            if (edge_no >= s && edge_no < s + PER && sample_tick) begin
                checks++;
                errors++;
                $display("FAIL sync_old_tick edge %0d got 1 want 0",
                         edge_no);
            end
            if (edge_no > s && mid_tick && mt < 0) mt = edge_no;
            if (edge_no > s && bit_tick && bt < 0) bt = edge_no;
        end
        checks++;
        if (mt != s + PER * OVS / 2) begin
            errors++;
            $display("FAIL sync_mid got %0d want %0d",
                     mt, s + PER * OVS / 2);
        end
        checks++;
        if (bt != s + PER * OVS) begin
            errors++;
            $display("FAIL sync_bit got %0d want %0d",
                     bt, s + PER * OVS);
        end
    endtask

    task automatic test_sync_on_term();
        int nxt;
        logic sy;
        nxt = -1;
        apply_reset();
        for (int i = 0; i < 2 * PER + 50; i++) begin
            sy = (edge_no + 1 == PER);
            step(1'b1, sy, 1'b0, 16'd0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL synct_model edge %0d got %h want %h",
                         edge_no, obs_vec(), exp_vec());
            end
            if (edge_no == PER) begin
                checks++;
                if ({sample_tick, bit_tick, mid_tick} !== 3'b000) begin
                    errors++;
                    $display("FAIL synct_tick got %b want 000",
                             {sample_tick, bit_tick, mid_tick});
                end
            end
            if (edge_no > PER && sample_tick && nxt < 0) nxt = edge_no;
        end
        checks++;
        if (nxt != 2 * PER) begin
            errors++;
            $display("FAIL synct_next got %0d want %0d", nxt, 2 * PER);
        end
    endtask

    task automatic test_zero_div_gating();
        int last;
        int nxt;
        logic ld;
        last = -1;
        nxt  = -1;
        apply_reset();
        for (int i = 0; i < 700; i++) begin
            ld = (edge_no + 1 == 10);
            step(1'b1, 1'b0, ld, 16'd0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL zero_model edge %0d got %h want %h",
                         edge_no, obs_vec(), exp_vec());
            end
            if (sample_tick) begin
                if (last >= PER) begin
                    checks++;
                    if (edge_no - last != 2) begin
                        errors++;
                        $display("FAIL zero_period got %0d want 2",
                                 edge_no - last);
                    end
                end
                last = edge_no;
            end
        end
        checks++;
        if (div_cur !== 16'd1) begin
            errors++;
            $display("FAIL zero_div got %0d want 1", div_cur);
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'd0);
            checks++;
            if (sample_tick !== 1'b0 || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL gate_idle edge %0d got %h want %h",
                         edge_no, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'd0);
            if (sample_tick && nxt < 0) nxt = edge_no;
        end
        checks++;
        if (nxt != last + 2 + 7) begin
            errors++;
            $display("FAIL gate_stretch got %0d want %0d",
                     nxt, last + 9);
        end
    endtask

    task automatic test_reset_mid();
        logic ld;
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            ld = (edge_no + 1 == 1990);
            step(1'b1, 1'b0, ld, ld ? 16'd100 : 16'd0);
        end
        checks++;
        if (load_pending !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pend got %b want 1", load_pending);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== {4'b0000, 16'(DEF)}) begin
            errors++;
            $display("FAIL rmid_async got %h want %h",
                     obs_vec(), {4'b0000, 16'(DEF)});
        end
        @(negedge clk);
        apply_reset();
        run_default_timing(5300);
    endtask

    task automatic test_random();
        logic ld;
        logic en;
        logic sy;
        logic [15:0] din;
        apply_reset();
        for (int i = 0; i < 20000; i++) begin
            ld  = ($urandom_range(0, 99) < 3);
            en  = (m_pend || ld) ? 1'b1 : ($urandom_range(0, 9) != 0);
            sy  = ($urandom_range(0, 299) == 0);
            din = 16'($urandom_range(0, 20));
            step(en, sy, ld, din);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rand_model edge %0d got %h want %h",
                         edge_no, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_defaults();
        test_reload();
        test_phase_sync();
        test_sync_on_term();
        test_zero_div_gating();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
